// File: rtl/dvi_cmd_extract.sv
// DVI in-band command extractor: finds a 5-pixel packet on one active line, validates header and checksum,
// publishes the command word and toggles a per-frame heartbeat. Define DVICMD_REDUNDANT_EN to also require R == ~G on payload pixels.
`ifndef MAX_DVICMD_BITS
`define MAX_DVICMD_BITS 18
`endif

module dvi_cmd_extract #(
    parameter logic [11:0] CMD_LINE = 12'd0,
    parameter logic [11:0] CMD_X0   = 12'd0,
    parameter logic [23:0] HEADER   = 24'h5AA55A
) (
    input  logic                        clkdvi,
    input  logic                        rst,
    input  logic                        vs,
    input  logic                        de,
    input  logic [23:0]                 rgb,
    output logic [`MAX_DVICMD_BITS-1:0] DviCmd_Temp,
    output logic                        cmd_valid,
    output logic                        wdt_clr,
    output logic [7:0]                  err_cnt,
    output logic                        debug
);

    localparam int CMD_W = `MAX_DVICMD_BITS;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_HDR,
        ST_PAY0,
        ST_PAY1,
        ST_PAY2,
        ST_CHK,
        ST_COMMIT
    } state_e;

    // Sync edge detection and raster position
    logic        vs_q;
    logic        de_q;
    logic        vs_rise;
    logic        de_fall;
    logic [11:0] line_cnt_q;
    logic [11:0] pix_cnt_q;

    assign vs_rise = vs & ~vs_q;
    assign de_fall = ~de & de_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkdvi or posedge rst) begin
        if (rst) begin
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            line_cnt_q <= 12'd0;
            pix_cnt_q  <= 12'd0;
        end else begin
            vs_q <= vs;
            de_q <= de;
            if (vs_rise) begin
                line_cnt_q <= 12'd0;
            end else if (de_fall && line_cnt_q != 12'hFFF) begin
                line_cnt_q <= line_cnt_q + 12'd1;
            end
            if (!de) begin
                pix_cnt_q <= 12'd0;
            end else if (pix_cnt_q != 12'hFFF) begin
                pix_cnt_q <= pix_cnt_q + 12'd1;
            end
        end
    end

    // Packet FSM
    state_e           state_q;
    state_e           cur_state;
    logic             armed_q;
    logic [7:0]       b0_q;
    logic [7:0]       b1_q;
    logic [7:0]       b2_q;
    logic             red_ok_q;
    logic [CMD_W-1:0] cmd_q;
    logic             cmd_valid_q;
    logic             wdt_clr_q;
    logic [7:0]       err_cnt_q;

    logic             trigger;
    logic             abort;
    logic             red_pix_ok;
    logic [7:0]       chk_sum;
    logic             sum_ok;
    logic [7:0]       err_sat;

    assign trigger = armed_q & de & ~vs_rise &
                     (line_cnt_q == CMD_LINE) & (pix_cnt_q == CMD_X0);
    assign abort   = vs_rise | ~de;

    // The header pixel is judged in the cycle it arrives, so HDR is the
    // effective state of that cycle and never needs its own register slot.
    assign cur_state = (state_q == ST_WAIT && trigger) ? ST_HDR : state_q;

`ifdef DVICMD_REDUNDANT_EN
    assign red_pix_ok = (rgb[23:16] == ~rgb[15:8]);
`else
    assign red_pix_ok = 1'b1;
`endif

    assign chk_sum = b0_q + b1_q + b2_q + rgb[15:8];
    assign sum_ok  = (chk_sum == 8'h00);
    assign err_sat = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_ff @(posedge clkdvi or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            armed_q     <= 1'b0;
            b0_q        <= 8'd0;
            b1_q        <= 8'd0;
            b2_q        <= 8'd0;
            red_ok_q    <= 1'b1;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            wdt_clr_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (vs_rise) begin
                armed_q <= 1'b1;
            end
            case (cur_state)
                ST_HDR: begin
                    armed_q  <= 1'b0;
                    red_ok_q <= 1'b1;
                    if (rgb == HEADER) begin
                        state_q <= ST_PAY0;
                    end else begin
                        err_cnt_q <= err_sat;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_PAY0: begin
                    if (abort) begin
                        err_cnt_q <= err_sat;
                        state_q   <= ST_WAIT;
                    end else begin
                        b0_q     <= rgb[15:8];
                        red_ok_q <= red_ok_q & red_pix_ok;
                        state_q  <= ST_PAY1;
                    end
                end
                ST_PAY1: begin
                    if (abort) begin
                        err_cnt_q <= err_sat;
                        state_q   <= ST_WAIT;
                    end else begin
                        b1_q     <= rgb[15:8];
                        red_ok_q <= red_ok_q & red_pix_ok;
                        state_q  <= ST_PAY2;
                    end
                end
                ST_PAY2: begin
                    if (abort) begin
                        err_cnt_q <= err_sat;
                        state_q   <= ST_WAIT;
                    end else begin
                        b2_q     <= rgb[15:8];
                        red_ok_q <= red_ok_q & red_pix_ok;
                        state_q  <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (abort || !(sum_ok && red_ok_q)) begin
                        err_cnt_q <= err_sat;
                        state_q   <= ST_WAIT;
                    end else begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    // Upper payload bits beyond the command width are dropped here.
                    cmd_q       <= CMD_W'({b2_q, b1_q, b0_q});
                    cmd_valid_q <= 1'b1;
                    wdt_clr_q   <= ~wdt_clr_q;
                    state_q     <= ST_WAIT;
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign DviCmd_Temp = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign wdt_clr     = wdt_clr_q;
    assign err_cnt     = err_cnt_q;
    assign debug       = (cur_state != ST_WAIT);

endmodule

// File: tb/tb_dvi_cmd_extract.sv
// Scoreboard bench for dvi_cmd_extract: directed frames push expected commits, a monitor checks each cmd_valid pulse.
`ifndef MAX_DVICMD_BITS
`define MAX_DVICMD_BITS 18
`endif

module tb_dvi_cmd_extract;

    localparam int CMD_W = `MAX_DVICMD_BITS;
    localparam logic [23:0] HDR = 24'h5AA55A;

    logic             clkdvi = 1'b0;
    logic             rst;
    logic             vs;
    logic             de;
    logic [23:0]      rgb;
    logic [CMD_W-1:0] DviCmd_Temp;
    logic             cmd_valid;
    logic             wdt_clr;
    logic [7:0]       err_cnt;
    logic             debug;

    dvi_cmd_extract #(
        .CMD_LINE (12'd0),
        .CMD_X0   (12'd0),
        .HEADER   (HDR)
    ) dut (
        .clkdvi      (clkdvi),
        .rst         (rst),
        .vs          (vs),
        .de          (de),
        .rgb         (rgb),
        .DviCmd_Temp (DviCmd_Temp),
        .cmd_valid   (cmd_valid),
        .wdt_clr     (wdt_clr),
        .err_cnt     (err_cnt),
        .debug       (debug)
    );

    always #5 clkdvi = ~clkdvi;

    int cyc = 0;
    always @(posedge clkdvi) cyc <= cyc + 1;

    typedef struct {
        logic [CMD_W-1:0] cmd;
        logic             wdt;
        int               due;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CMD_W-1:0] exp_cmd;
    logic             exp_wdt;
    logic [7:0]       exp_err;
    logic [23:0]      pkt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every commit pulse must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clkdvi);
            if (cmd_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got cmd 0x%0h at cycle %0d, expected no commit",
                             DviCmd_Temp, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("commit_cmd", 32'(DviCmd_Temp), 32'(mon_e.cmd));
                    check("commit_wdt", 32'(wdt_clr), 32'(mon_e.wdt));
                    check("commit_latency", 32'(cyc), 32'(mon_e.due));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clkdvi);
        #1;
    endtask

    task automatic vsync();
        vs = 1'b1;
        tick();
        tick();
        vs = 1'b0;
        tick();
        tick();
    endtask

    task automatic set_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] k, input logic [23:0] hdr);
        pkt[0] = hdr;
        pkt[1] = {~b0, b0, 8'h00};
        pkt[2] = {~b1, b1, 8'h00};
        pkt[3] = {~b2, b2, 8'h00};
        pkt[4] = {~k, k, 8'h00};
    endtask

    // One frame: vsync, then a single active line of len pixels carrying pkt.
    task automatic send_frame(input int len, input bit commit, input logic [CMD_W-1:0] cmd);
        vsync();
        if (commit) begin
            exp_cmd = cmd;
            exp_wdt = ~exp_wdt;
        end
        for (int i = 0; i < len; i++) begin
            de  = 1'b1;
            rgb = (i < 5) ? pkt[i] : 24'h0F0F0F;
            if (commit && i == 4) sb_q.push_back('{cmd: exp_cmd, wdt: exp_wdt, due: cyc + 2});
            tick();
        end
        de  = 1'b0;
        rgb = 24'h0;
        repeat (4) tick();
    endtask

    task automatic state_checks(input string tag);
        check({tag, "_cmd"}, 32'(DviCmd_Temp), 32'(exp_cmd));
        check({tag, "_wdt"}, 32'(wdt_clr), 32'(exp_wdt));
        check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
        check({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        vs      = 1'b0;
        de      = 1'b0;
        rgb     = 24'h0;
        exp_cmd = '0;
        exp_wdt = 1'b0;
        exp_err = 8'd0;

        repeat (3) @(posedge clkdvi);
        #1;
        check("reset_cmd", 32'(DviCmd_Temp), 32'd0);
        check("reset_valid", 32'(cmd_valid), 32'd0);
        check("reset_wdt", 32'(wdt_clr), 32'd0);
        check("reset_err", 32'(err_cnt), 32'd0);
        check("reset_debug", 32'(debug), 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Valid packet: B0=34 B1=12 B2=03 K=B7 -> 0x31234
        set_pkt(8'h34, 8'h12, 8'h03, 8'hB7, HDR);
        send_frame(8, 1'b1, 18'h31234);
        state_checks("valid");

        // Bad checksum
        set_pkt(8'h34, 8'h12, 8'h03, 8'hB6, HDR);
        send_frame(8, 1'b0, '0);
        exp_err = 8'd1;
        state_checks("bad_sum");

        // Bad header, otherwise valid payload
        set_pkt(8'h34, 8'h12, 8'h03, 8'hB7, 24'h5AA55B);
        send_frame(8, 1'b0, '0);
        exp_err = 8'd2;
        state_checks("bad_hdr");

        // Line ends after P2
        set_pkt(8'h34, 8'h12, 8'h03, 8'hB7, HDR);
        send_frame(3, 1'b0, '0);
        exp_err = 8'd3;
        state_checks("short_line");

        // Recovery: B0=FF B1=EE B2=01, sum 0x1EE -> K=12, word 0x1EEFF
        set_pkt(8'hFF, 8'hEE, 8'h01, 8'h12, HDR);
        send_frame(8, 1'b1, 18'h1EEFF);
        state_checks("recover");

        // vs rises while P2 is on the wire
        set_pkt(8'h34, 8'h12, 8'h03, 8'hB7, HDR);
        vsync();
        de  = 1'b1;
        rgb = pkt[0];
        tick();
        rgb = pkt[1];
        tick();
        vs  = 1'b1;
        rgb = pkt[2];
        tick();
        de  = 1'b0;
        rgb = 24'h0;
        tick();
        tick();
        vs = 1'b0;
        tick();
        tick();
        exp_err = 8'd4;
        state_checks("vs_abort");

        // Frames without any active line
        repeat (10) begin
            vsync();
            repeat (8) tick();
        end
        state_checks("no_packet");

        // Error counter saturation
        set_pkt(8'h34, 8'h12, 8'h03, 8'hB6, HDR);
        repeat (300) send_frame(6, 1'b0, '0);
        exp_err = 8'd255;
        state_checks("err_sat");
        send_frame(6, 1'b0, '0);
        state_checks("err_hold");

        // Reset while in PAY1
        set_pkt(8'h34, 8'h12, 8'h03, 8'hB7, HDR);
        vsync();
        de  = 1'b1;
        rgb = pkt[0];
        tick();
        rgb = pkt[1];
        tick();
        rgb = pkt[2];
        #2;
        rst = 1'b1;
        #1;
        exp_cmd = '0;
        exp_wdt = 1'b0;
        exp_err = 8'd0;
        check("midrst_valid", 32'(cmd_valid), 32'd0);
        check("midrst_debug", 32'(debug), 32'd0);
        state_checks("midrst");
        de  = 1'b0;
        rgb = 24'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        send_frame(8, 1'b1, 18'h31234);
        state_checks("post_rst");

        // P2 carries R != ~G
        set_pkt(8'h21, 8'h43, 8'h02, 8'h9A, HDR);
        pkt[2] = {8'h43, 8'h43, 8'h00};
`ifdef DVICMD_REDUNDANT_EN
        send_frame(8, 1'b0, '0);
        exp_err = 8'd1;
        state_checks("redundant_bad");
`else
        send_frame(8, 1'b1, 18'h24321);
        state_checks("redundant_ignored");
`endif

        repeat (5) tick();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
